// File: rtl/pll_pi_filter.sv
// Proportional-integral loop filter for a digital PLL. A two-stage pipeline turns phase-error
// samples into a clamped NCO frequency word, and an ACQ/TRACK/HOLD controller selects the loop gains.
module pll_pi_filter #(
  parameter int FW        = 24,
  parameter int EW        = 8,
  parameter int IW        = FW + 2,
  parameter int ACQ_BOOST = 2,
  parameter int LOCK_N    = 16,
  parameter int UNLOCK_N  = 4,
  parameter logic [FW-1:0] F_RESET = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          err_valid,
  input  logic [EW-1:0] err,
  input  logic [4:0]    kp_sh,
  input  logic [4:0]    ki_sh,
  input  logic [EW-1:0] lock_thresh,
  input  logic          hold,
  input  logic          load,
  input  logic [FW-1:0] f_center,
  output logic [FW-1:0] freq_word,
  output logic          fw_valid,
  output logic          locked,
  output logic [1:0]    state
);

  localparam int LW = $clog2(LOCK_N + 1);
  localparam int UW = $clog2(UNLOCK_N + 1);
  localparam logic signed [IW:0] FMAX = {{(IW+1-FW){1'b0}}, {FW{1'b1}}};

  typedef enum logic [1:0] {ACQ = 2'd0, TRACK = 2'd1, HOLD = 2'd2} state_t;

  function automatic logic [4:0] eff_sh(input logic [4:0] sh, input logic acq);
    if (!acq) return sh;
    if (int'(sh) > ACQ_BOOST) return sh - 5'(ACQ_BOOST);
    return 5'd0;
  endfunction

  function automatic logic signed [IW-1:0] ashr(input logic signed [IW-1:0] v, input logic [4:0] sh);
    if (int'(sh) >= IW) return {IW{v[IW-1]}};
    return v >>> sh;
  endfunction

  function automatic logic [FW-1:0] clamp_fw(input logic signed [IW:0] v);
    if (v[IW]) return '0;
    if (v > FMAX) return '1;
    return v[FW-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [FW-1:0]       iacc_q, iacc_d, fw_q, fw_d;
  logic                fwv_q, fwv_d;
  logic [LW-1:0]       lock_q, lock_d, lock_inc;
  logic [UW-1:0]       unlock_q, unlock_d, unlock_inc;

  logic                vld_p0, acq_p0;
  logic signed [EW:0]  errx_p0;
  logic [EW:0]         abs_p0;
  logic signed [IW-1:0] es_p0, p_p0, i_p0;

  logic                vld_p1;
  logic signed [IW-1:0] p_p1, i_p1;
  logic [EW:0]         abs_p1;

  logic signed [IW:0]  isum, psum;
  logic [FW-1:0]       iacc_new;
  logic                in_th;

  // Stage 0: scale the error and apply the gains of the current state
  assign acq_p0  = (state_q == ACQ);
  assign vld_p0  = err_valid && !hold && !load && (state_q != HOLD);
  assign errx_p0 = $signed({err[EW-1], err});
  assign abs_p0  = errx_p0[EW] ? unsigned'(-errx_p0) : unsigned'(errx_p0);
  assign es_p0   = $signed({{(IW-EW){err[EW-1]}}, err}) <<< (FW-EW);
  assign p_p0    = ashr(es_p0, eff_sh(kp_sh, acq_p0));
  assign i_p0    = ashr(es_p0, eff_sh(ki_sh, acq_p0));

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      p_p1   <= p_p0;
      i_p1   <= i_p0;
      abs_p1 <= abs_p0;
    end
  end

  // Stage 1 -> 2: integrator and output clamp to the NCO range, so neither can wind up
  assign isum     = $signed({{(IW+1-FW){1'b0}}, iacc_q}) + $signed({i_p1[IW-1], i_p1});
  assign iacc_new = clamp_fw(isum);
  assign psum     = $signed({{(IW+1-FW){1'b0}}, iacc_new}) + $signed({p_p1[IW-1], p_p1});
  assign in_th    = abs_p1 <= {1'b0, lock_thresh};
  assign lock_inc   = (lock_q >= LW'(LOCK_N)) ? lock_q : lock_q + 1'b1;
  assign unlock_inc = (unlock_q >= UW'(UNLOCK_N)) ? unlock_q : unlock_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    iacc_d   = iacc_q;
    fw_d     = fw_q;
    fwv_d    = 1'b0;
    lock_d   = lock_q;
    unlock_d = unlock_q;
    if (load) begin
      iacc_d   = f_center;
      fw_d     = f_center;
      fwv_d    = 1'b1;
      lock_d   = '0;
      unlock_d = '0;
      state_d  = hold ? HOLD : ACQ;
    end else if (hold) begin
      state_d  = HOLD;
      lock_d   = '0;
      unlock_d = '0;
    end else if (state_q == HOLD) begin
      state_d = ACQ;
    end else if (vld_p1) begin
      iacc_d   = iacc_new;
      fw_d     = clamp_fw(psum);
      fwv_d    = 1'b1;
      lock_d   = in_th ? lock_inc : '0;
      unlock_d = in_th ? '0 : unlock_inc;
      if (state_q == ACQ && lock_d == LW'(LOCK_N)) state_d = TRACK;
      else if (state_q == TRACK && unlock_d == UW'(UNLOCK_N)) state_d = ACQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACQ;
      iacc_q   <= F_RESET;
      fw_q     <= F_RESET;
      fwv_q    <= 1'b0;
      lock_q   <= '0;
      unlock_q <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iacc_q   <= iacc_d;
      fw_q     <= fw_d;
      fwv_q    <= fwv_d;
      lock_q   <= lock_d;
      unlock_q <= unlock_d;
      vld_p1   <= vld_p0;
    end
  end

  assign freq_word = fw_q;
  assign fw_valid  = fwv_q;
  assign locked    = (state_q == TRACK);
  assign state     = state_q;

endmodule

// File: tb/tb_pll_pi_filter.sv
// Bench for pll_pi_filter: hand-computed vector table, directed corner sequences and a
// randomized run, all compared each cycle against an arithmetic reference model.
module tb_pll_pi_filter;

  logic        clk = 1'b0, rst_n = 1'b0, err_valid = 1'b0, hold = 1'b0, load = 1'b0;
  logic [7:0]  err = '0, lock_thresh = '0;
  logic [4:0]  kp_sh = 5'd8, ki_sh = 5'd8;
  logic [23:0] f_center = '0;
  logic [23:0] freq_word;
  logic        fw_valid, locked;
  logic [1:0]  state;

  pll_pi_filter dut (
    .clk(clk), .rst_n(rst_n), .err_valid(err_valid), .err(err), .kp_sh(kp_sh), .ki_sh(ki_sh),
    .lock_thresh(lock_thresh), .hold(hold), .load(load), .f_center(f_center),
    .freq_word(freq_word), .fw_valid(fw_valid), .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: values as plain integers, in-flight samples in a queue
  typedef struct { longint p; longint i; int a; } samp_t;
  samp_t  pend[$];
  longint m_iacc, m_fw;
  bit     m_fwv;
  int     m_state, m_lock, m_unlock;
  localparam longint FMAX = longint'(16777215);

  function automatic longint clampf(input longint v);
    if (v < 0) return 0;
    if (v > FMAX) return FMAX;
    return v;
  endfunction

  task automatic model_reset();
    m_iacc = 0; m_fw = 0; m_fwv = 0; m_state = 0; m_lock = 0; m_unlock = 0;
    pend.delete();
  endtask

  task automatic model_step();
    samp_t  s, old;
    bit     cap, have;
    int     kpe, kie;
    longint es;
    if (!rst_n) begin model_reset(); return; end
    cap = err_valid && !hold && !load && (m_state != 2);
    if (cap) begin
      kpe = int'(kp_sh); kie = int'(ki_sh);
      if (m_state == 0) begin
        kpe = (kpe > 2) ? kpe - 2 : 0;
        kie = (kie > 2) ? kie - 2 : 0;
      end
      es  = longint'($signed(err)) * 65536;
      s.p = es >>> kpe;
      s.i = es >>> kie;
      s.a = (es < 0) ? -int'($signed(err)) : int'($signed(err));
    end
    have = (pend.size() > 0);
    if (have) old = pend.pop_front();
    m_fwv = 0;
    if (load) begin
      m_iacc = longint'(f_center); m_fw = longint'(f_center); m_fwv = 1;
      m_lock = 0; m_unlock = 0; m_state = hold ? 2 : 0;
    end else if (hold) begin
      m_state = 2; m_lock = 0; m_unlock = 0;
    end else if (m_state == 2) begin
      m_state = 0;
    end else if (have) begin
      m_iacc = clampf(m_iacc + old.i);
      m_fw   = clampf(m_iacc + old.p);
      m_fwv  = 1;
      if (old.a <= int'(lock_thresh)) begin
        m_lock = (m_lock < 16) ? m_lock + 1 : 16; m_unlock = 0;
      end else begin
        m_unlock = (m_unlock < 4) ? m_unlock + 1 : 4; m_lock = 0;
      end
      if (m_state == 0 && m_lock == 16) m_state = 1;
      else if (m_state == 1 && m_unlock == 4) m_state = 0;
    end
    if (cap) pend.push_back(s);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("freq_word", 64'(freq_word), m_fw);
    chk("fw_valid", 64'(fw_valid), 64'(m_fwv));
    chk("state", 64'(state), 64'(m_state));
    chk("locked", 64'(locked), 64'(m_state == 1));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_freq_word", 64'(freq_word), 64'h0);
    chk("rst_fw_valid", 64'(fw_valid), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_state", 64'(state), 64'h0);
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [23:0] fc;
    logic [7:0]  e;
    logic [4:0]  kp, ki;
    logic [23:0] exp_fw;
  } vec_t;
  vec_t vt[8];

  initial begin
    int n;
    bit reached;
    vt[0] = '{24'h400000, 8'h01, 5'd8,  5'd8,  24'h400800};
    vt[1] = '{24'h400000, 8'hFF, 5'd10, 5'd12, 24'h3FFEC0};
    vt[2] = '{24'h000010, 8'h80, 5'd0,  5'd0,  24'h000000};
    vt[3] = '{24'hFFFFF0, 8'h7F, 5'd1,  5'd1,  24'hFFFFFF};
    vt[4] = '{24'h123456, 8'hFD, 5'd31, 5'd31, 24'h123454};
    vt[5] = '{24'h123456, 8'h05, 5'd31, 5'd2,  24'h173456};
    vt[6] = '{24'h000000, 8'h02, 5'd3,  5'd4,  24'h018000};
    vt[7] = '{24'h800000, 8'hF9, 5'd2,  5'd27, 24'h78FFFF};

    model_reset();
    #2;
    chk("init_freq_word", 64'(freq_word), 64'h0);
    chk("init_fw_valid", 64'(fw_valid), 64'h0);
    chk("init_state", 64'(state), 64'h0);
    chk("init_locked", 64'(locked), 64'h0);
    #10 rst_n = 1'b1;

    // Lock acquisition: 16 zero-error samples, locked with the 16th output
    lock_thresh = 8'd2; kp_sh = 5'd8; ki_sh = 5'd8; err = 8'd0;
    err_valid = 1'b1; n = 0;
    for (int t = 0; t < 17; t++) begin
      if (t == 16) err_valid = 1'b0;
      tick();
      if (fw_valid) begin n++; chk("lock_rise", 64'(locked), 64'(n == 16)); end
    end
    chk("lock_pulses", 64'(n), 64'd16);

    err = 8'd1; err_valid = 1'b1;
    tick(); chk("track_lat1", 64'(fw_valid), 64'h0);
    err_valid = 1'b0;
    tick(); chk("track_step_fwv", 64'(fw_valid), 64'h1);
    chk("track_step", 64'(freq_word), 64'h000200);

    err = 8'd3; err_valid = 1'b1; n = 0;
    for (int t = 0; t < 5; t++) begin
      if (t == 4) err_valid = 1'b0;
      tick();
      if (fw_valid) begin n++; chk("lock_fall", 64'(locked), 64'(n < 4)); end
    end
    chk("unlock_pulses", 64'(n), 64'd4);

    // Single-sample vectors from a loaded integrator, ACQ gains
    lock_thresh = 8'd0;
    for (int v = 0; v < 8; v++) begin
      load = 1'b1; f_center = vt[v].fc;
      tick();
      chk("vec_load_fw", 64'(freq_word), 64'(vt[v].fc));
      chk("vec_load_fwv", 64'(fw_valid), 64'h1);
      load = 1'b0; err = vt[v].e; kp_sh = vt[v].kp; ki_sh = vt[v].ki; err_valid = 1'b1;
      tick(); chk("vec_lat1", 64'(fw_valid), 64'h0);
      err_valid = 1'b0;
      tick(); chk("vec_fwv", 64'(fw_valid), 64'h1);
      chk("vec_fw", 64'(freq_word), 64'(vt[v].exp_fw));
    end

    // No windup below zero, then immediate recovery
    do_reset();
    kp_sh = 5'd8; ki_sh = 5'd8; err = 8'h80; err_valid = 1'b1;
    for (int t = 0; t < 21; t++) begin
      if (t == 20) err_valid = 1'b0;
      tick();
      if (fw_valid) chk("windup_low", 64'(freq_word), 64'h0);
    end
    err = 8'd1; err_valid = 1'b1;
    tick(); err_valid = 1'b0;
    tick(); chk("windup_recover", 64'(freq_word), 64'h000800);

    // Saturation at the top of the range
    err = 8'h7F; err_valid = 1'b1; reached = 1'b0;
    for (int t = 0; t < 400 && !reached; t++) begin
      tick();
      if (freq_word == 24'hFFFFFF) reached = 1'b1;
    end
    chk("sat_reached", 64'(reached), 64'h1);
    for (int t = 0; t < 10; t++) begin
      tick(); chk("sat_hold", 64'(freq_word), 64'hFFFFFF);
    end
    err_valid = 1'b0;
    tick(); tick();

    // Hold freezes the loop while samples keep arriving
    load = 1'b1; f_center = 24'h300000;
    tick();
    load = 1'b0; err_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin err = 8'($urandom_range(0, 8) - 4); tick(); end
    hold = 1'b1;
    for (int t = 0; t < 5; t++) begin
      err = 8'($urandom);
      tick();
      chk("hold_no_fwv", 64'(fw_valid), 64'h0);
      chk("hold_state", 64'(state), 64'h2);
    end
    hold = 1'b0;
    tick(); chk("hold_exit_state", 64'(state), 64'h0);
    tick(); chk("hold_restart_lat", 64'(fw_valid), 64'h0);
    tick(); chk("hold_restart_fwv", 64'(fw_valid), 64'h1);
    err_valid = 1'b0;
    tick(); tick();

    // Load discards the sample sitting in stage 1
    err = 8'd50; err_valid = 1'b1;
    tick();
    err_valid = 1'b0; load = 1'b1; f_center = 24'h400000;
    tick();
    chk("load_fw", 64'(freq_word), 64'h400000);
    chk("load_fwv", 64'(fw_valid), 64'h1);
    chk("load_state", 64'(state), 64'h0);
    load = 1'b0;
    tick();
    chk("load_discard_fwv", 64'(fw_valid), 64'h0);
    chk("load_discard_fw", 64'(freq_word), 64'h400000);

    // Load during hold presets values but stays in HOLD
    hold = 1'b1;
    tick();
    load = 1'b1; f_center = 24'h123456;
    tick();
    chk("hold_load_fw", 64'(freq_word), 64'h123456);
    chk("hold_load_fwv", 64'(fw_valid), 64'h1);
    chk("hold_load_state", 64'(state), 64'h2);
    load = 1'b0; hold = 1'b0;
    tick(); tick();

    // Asynchronous reset in the middle of a stream
    err = 8'd20; err_valid = 1'b1;
    tick(); tick(); tick();
    do_reset();
    tick(); chk("first_after_rst_lat", 64'(fw_valid), 64'h0);
    tick(); chk("first_after_rst_fwv", 64'(fw_valid), 64'h1);
    err_valid = 1'b0;
    tick();

    // Randomized run
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        kp_sh = 5'($urandom); ki_sh = 5'($urandom); lock_thresh = 8'($urandom_range(0, 6));
      end
      err_valid = ($urandom_range(0, 9) < 7);
      if ((c % 400) < 200) err = ($urandom_range(0, 9) < 9) ? 8'($urandom_range(0, 8) - 4) : 8'($urandom);
      else err = 8'($urandom);
      hold = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 79) == 0);
      f_center = 24'($urandom);
      tick();
    end
    hold = 1'b0; load = 1'b0; err_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_pi_filter.md
PLL_PI_FILTER -- requirements
Module: pll_pi_filter

Interface
REQ-001 SHALL have parameter FW, default 24: width of the unsigned frequency control word.
REQ-002 SHALL have parameter EW, default 8: width of the signed phase-error input.
REQ-003 SHALL have parameter IW, default FW+2: width of the signed integrator.
REQ-004 SHALL have parameter ACQ_BOOST, default 2: gain-shift reduction applied in ACQ.
REQ-005 SHALL have parameter LOCK_N, default 16: consecutive in-threshold samples needed to declare lock.
REQ-006 SHALL have parameter UNLOCK_N, default 4: consecutive out-of-threshold samples needed to drop lock.
REQ-007 SHALL have parameter F_RESET, default 0: freq_word and integrator reset value.
REQ-008 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port err_valid, input, 1 bit: err sample strobe.
REQ-011 SHALL have port err, input, EW bits: signed phase error, two's complement.
REQ-012 SHALL have port kp_sh, input, 5 bits: proportional right-shift.
REQ-013 SHALL have port ki_sh, input, 5 bits: integral right-shift.
REQ-014 SHALL have port lock_thresh, input, EW bits: unsigned |err| lock threshold.
REQ-015 SHALL have port hold, input, 1 bit: level; freeze loop.
REQ-016 SHALL have port load, input, 1 bit: pulse; preset integrator to f_center.
REQ-017 SHALL have port f_center, input, FW bits: unsigned preset value.
REQ-018 SHALL have port freq_word, output, FW bits: unsigned NCO increment, registered.
REQ-019 SHALL have port fw_valid, output, 1 bit: one-cycle strobe on every freq_word update.
REQ-020 SHALL have port locked, output, 1 bit: high in TRACK only.
REQ-021 SHALL have port state, output, 2 bits: ACQ=0, TRACK=1, HOLD=2.

Function
REQ-022 Scaled error SHALL be: e_s = sext(err) <<< (FW-EW) to IW bits; effective shifts = kp_sh/ki_sh in TRACK, max(0, sh-ACQ_BOOST) in ACQ.
REQ-023 Terms SHALL be: p = e_s >>> kp_eff, i = e_s >>> ki_eff (arithmetic, round toward minus infinity); shifts >= IW give 0 or -1 per sign.
REQ-024 Stage 1 SHALL register p, i, |err| (EW+1 bits, so |-2^(EW-1)| = 2^(EW-1)) and valid; stage 2 SHALL update the integrator and output.
REQ-025 Latency SHALL be exactly 2 cycles: err_valid at edge N -> fw_valid and new freq_word at edge N+2; full throughput, one sample per cycle.
REQ-026 Integrator SHALL be: iacc <= clamp(iacc + i, 0, 2^FW-1) (anti-windup; never leaves the output range).
REQ-027 Output SHALL be: freq_word <= clamp(iacc_new + p, 0, 2^FW-1); freq_word holds between valid samples.
REQ-028 ACQ -> TRACK SHALL occur when lock_cnt reaches LOCK_N; lock_cnt counts consecutive stage-1 samples with |err| <= lock_thresh and any out-of-threshold sample clears it.
REQ-029 TRACK -> ACQ SHALL occur when unlock_cnt reaches UNLOCK_N; unlock_cnt counts consecutive samples with |err| > lock_thresh and any in-threshold sample clears it.
REQ-030 Any state -> HOLD SHALL occur when hold=1: integrator and freq_word frozen, err samples dropped (no fw_valid), both counters cleared, locked=0.
REQ-031 HOLD -> ACQ SHALL occur on the cycle after hold deasserts; the pipeline restarts empty.
REQ-032 load=1 SHALL, next edge: iacc=f_center, freq_word=f_center, fw_valid=1, state=ACQ, counters cleared, in-flight stage-1 sample discarded.
REQ-033 Priority SHALL be load > hold > err_valid; load during hold presets the values and the block remains in HOLD.
REQ-034 State and counter transitions SHALL take effect at the same edge as the stage-2 update of the sample that triggers them; gains for a sample are those of the state at stage-1 capture.
REQ-035 Counters SHALL saturate at their target and not wrap.

Reset
REQ-036 On rst_n low, asynchronously: freq_word=F_RESET, iacc=F_RESET, fw_valid=0, locked=0, state=ACQ, counters=0, pipeline valids=0.
REQ-037 First err_valid accepted after rst_n rises SHALL produce fw_valid 2 cycles later.

Verification
REQ-038 Reset, FW=24, EW=8, kp_sh=ki_sh=8, TRACK forced via 16 zero-error samples, single err=+1 -> p=i=0x0100, freq_word=0x000200 at N+2.
REQ-039 err=0 for 16 valid samples, lock_thresh=2 -> locked rises with the 16th fw_valid; then err=+3 for 4 samples -> locked falls with the 4th.
REQ-040 err=-128 repeatedly from F_RESET=0 -> freq_word and iacc stay 0 (no windup); then err=+1 -> freq_word rises on the first sample.
REQ-041 err=+127 streamed until freq_word=0xFFFFFF -> value stays saturated with no wrap; same sequence in ACQ vs TRACK -> ACQ step 4x larger.
REQ-042 hold=1 mid-stream with err_valid=1 -> no fw_valid, freq_word constant; hold=0 -> state=ACQ, next sample output 2 cycles later.
REQ-043 load with f_center=0x400000 while a sample is in stage 1 -> freq_word=0x400000 with fw_valid next edge; discarded sample produces no output; rst_n pulsed mid-stream -> all outputs at reset values immediately.
